// File: rtl/shift_add_multiplier.sv
// Multi-cycle WIDTH x WIDTH -> 2*WIDTH multiplier, one add and one shift per clock.
// Define MUL_SIGNED_EN to treat a/b as two's-complement (sign-magnitude around the unsigned core).
module shift_add_multiplier #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product,
    output logic               overflow
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state;
    logic [CW-1:0]      cnt;
    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   acc_hi;
    logic [WIDTH-1:0]   acc_lo;
    logic [WIDTH:0]     hi_next;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [2*WIDTH-1:0] res;
    logic               res_ov;

    // Carry lands in bit WIDTH and is shifted straight back into acc_hi, so no carry register survives a step.
    always_comb begin
        hi_next = {1'b0, acc_hi};
        if (acc_lo[0])
            hi_next = {1'b0, acc_hi} + {1'b0, mcand};
    end

`ifdef MUL_SIGNED_EN
    logic neg;

    // Magnitude of the most negative value still fits unsigned in WIDTH bits.
    always_comb begin
        a_mag  = a[WIDTH-1] ? WIDTH'(-a) : a;
        b_mag  = b[WIDTH-1] ? WIDTH'(-b) : b;
        res    = neg ? (2*WIDTH)'(-{acc_hi, acc_lo}) : {acc_hi, acc_lo};
        res_ov = !((&res[2*WIDTH-1:WIDTH-1]) || !(|res[2*WIDTH-1:WIDTH-1]));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            neg <= 1'b0;
        else if (state == IDLE && start)
            neg <= a[WIDTH-1] ^ b[WIDTH-1];
    end
`else
    always_comb begin
        a_mag  = a;
        b_mag  = b;
        res    = {acc_hi, acc_lo};
        res_ov = |res[2*WIDTH-1:WIDTH];
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            mcand    <= '0;
            acc_hi   <= '0;
            acc_lo   <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            product  <= '0;
            overflow <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        mcand  <= a_mag;
                        acc_hi <= '0;
                        acc_lo <= b_mag;
                        cnt    <= '0;
                        busy   <= 1'b1;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    {acc_hi, acc_lo} <= {hi_next, acc_lo[WIDTH-1:1]};
                    cnt <= cnt + CW'(1);
                    if (cnt == CW'(WIDTH - 1))
                        state <= DONE;
                end
                DONE: begin
                    product  <= res;
                    overflow <= res_ov;
                    done     <= 1'b1;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
